// File: rtl/mac3_pkg.sv
// mac3_stream shared types: fill states and the
// overflow/saturation helper used by the top.
package mac3_pkg;

  localparam int MAX_W = 129;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO,
    FULL
  } fill_e;

  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             ovf;
  } sat_t;

  function automatic sat_t mac3_sat(
    input logic [MAX_W-1:0] s,
    input int               acc_w,
    input bit               saturate
  );
    logic [MAX_W-1:0] mask;
    sat_t             r;
    mask  = (MAX_W'(1) << acc_w) - MAX_W'(1);
    r.ovf = (s & ~mask) != '0;
    r.res = (saturate && r.ovf) ? mask : (s & mask);
    return r;
  endfunction

endpackage

// File: rtl/mac3_stream_if.sv
// mac3_stream sample/result bus.
// master drives samples, slave is the unit.
interface mac3_stream_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
);
  logic              validi;
  logic [DATA_W-1:0] data_in;
  logic              clr;
  logic              valido;
  logic [ACC_W-1:0]  data_out;
  logic              ovf;

  modport master (
    output validi, data_in, clr,
    input  valido, data_out, ovf
  );

  modport slave (
    input  validi, data_in, clr,
    output valido, data_out, ovf
  );
endinterface

// File: rtl/mac3_stream_window.sv
// mac3 fill tracker and two-deep sample history.
// win_full marks a sample that completes a 3-window.
module mac3_window
  import mac3_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validi,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  output logic              win_full,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2
);

  fill_e state, nxt;
  logic  take;

  assign take     = validi && !clr;
  assign win_full = validi &&
                    (state == TWO || state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= nxt;
  end

  always_comb begin
    nxt = EMPTY;
    if (take) begin
      unique case (state)
        EMPTY:   nxt = ONE;
        ONE:     nxt = TWO;
        TWO:     nxt = FULL;
        FULL:    nxt = FULL;
        default: nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1 <= '0;
      w2 <= '0;
    end else if (take) begin
      w2 <= w1;
      w1 <= data_in;
    end
  end

endmodule

// File: rtl/mac3_stream.sv
// Streaming a*b+c over three consecutive valid
// samples, with wrap/saturate and overflow flag.
module mac3_stream
  import mac3_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input logic         clk,
  input logic         rst_n,
  mac3_stream_if.slave bus
);

  localparam int SW = 2*DATA_W + 1;

  logic              win_full;
  logic [DATA_W-1:0] w1, w2;
  logic [SW-1:0]     sum;
  sat_t              r;
  logic              unused_res;

  logic              valid_q;
  logic              ovf_q;
  logic [ACC_W-1:0]  dout_q;

  mac3_window #(.DATA_W(DATA_W)) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .validi   (bus.validi),
    .clr      (bus.clr),
    .data_in  (bus.data_in),
    .win_full (win_full),
    .w1       (w1),
    .w2       (w2)
  );

  assign sum = SW'(w2) * SW'(w1) + SW'(bus.data_in);
  assign r   = mac3_sat(MAX_W'(sum), ACC_W,
                        SATURATE != 0);
  // bits above ACC_W are zero by construction
  assign unused_res = ^r.res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else if (bus.clr) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else if (win_full) begin
      valid_q <= 1'b1;
      ovf_q   <= r.ovf;
      dout_q  <= r.res[ACC_W-1:0];
    end else begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign bus.valido   = valid_q;
  assign bus.ovf      = ovf_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_mac3_stream.sv
// Bench for mac3_stream: three configurations driven
// in lockstep and compared to a queue-based model.
module tb_mac3_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac3_stream_if #(.DATA_W(32), .ACC_W(32)) if0 ();
  mac3_stream_if #(.DATA_W(32), .ACC_W(32)) if1 ();
  mac3_stream_if #(.DATA_W(8),  .ACC_W(17)) if2 ();

  mac3_stream #(.DATA_W(32), .ACC_W(32), .SATURATE(0))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mac3_stream #(.DATA_W(32), .ACC_W(32), .SATURATE(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mac3_stream #(.DATA_W(8),  .ACC_W(17), .SATURATE(0))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int total = 0;
  int bad   = 0;

  int dw_c [3] = '{32, 32, 8};
  int aw_c [3] = '{32, 32, 17};
  bit sat_c[3] = '{1'b0, 1'b1, 1'b0};

  logic [31:0] hq [3][$];
  logic        ev [3];
  logic        eo [3];
  logic [31:0] ed [3];

  logic [31:0] ad [3];
  logic        av [3];
  logic        ao [3];

  always_comb begin
    ad[0] = if0.data_out;
    ad[1] = if1.data_out;
    ad[2] = 32'(if2.data_out);
    av[0] = if0.valido;
    av[1] = if1.valido;
    av[2] = if2.valido;
    ao[0] = if0.ovf;
    ao[1] = if1.ovf;
    ao[2] = if2.ovf;
  end

  function automatic void ref_mac(
    input  logic [31:0] a, b, c,
    input  int          aw,
    input  bit          sat,
    output logic [31:0] res,
    output logic        o
  );
    logic [127:0] s, m;
    s   = 128'(a) * 128'(b) + 128'(c);
    m   = (128'(1) << aw) - 128'(1);
    o   = s > m;
    res = 32'((sat && o) ? m : (s & m));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hq[k].delete();
      ev[k] = 1'b0;
      eo[k] = 1'b0;
      ed[k] = '0;
    end
  endtask

  task automatic step(input bit v, input bit c,
                      input logic [31:0] d);
    logic [31:0] x, msk, r;
    logic        o;
    if0.validi = v; if0.clr = c; if0.data_in = d;
    if1.validi = v; if1.clr = c; if1.data_in = d;
    if2.validi = v; if2.clr = c; if2.data_in = d[7:0];
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        hq[k].delete();
        ev[k] = 1'b0; eo[k] = 1'b0; ed[k] = '0;
      end else if (!v) begin
        hq[k].delete();
        ev[k] = 1'b0; eo[k] = 1'b0;
      end else begin
        msk = (dw_c[k] == 32) ? 32'hFFFF_FFFF
                              : (32'd1 << dw_c[k]) - 32'd1;
        x = d & msk;
        hq[k].push_back(x);
        if (hq[k].size() > 3) void'(hq[k].pop_front());
        if (hq[k].size() == 3) begin
          ref_mac(hq[k][0], hq[k][1], hq[k][2],
                  aw_c[k], sat_c[k], r, o);
          ev[k] = 1'b1; eo[k] = o; ed[k] = r;
        end else begin
          ev[k] = 1'b0; eo[k] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (av[k] !== 1'b0 || ad[k] !== 32'd0 ||
          ao[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state dut%0d got v=%b d=%h o=%b exp 0/0/0",
                 k, av[k], ad[k], ao[k]);
      end
    end
    step(1, 0, 2);
    step(1, 0, 3);
    step(1, 0, 4);
    total++;
    if (av[0] !== 1'b1 || ad[0] !== 32'd10) begin
      bad++;
      $display("FAIL pre_reset got v=%b d=%0d exp v=1 d=10",
               av[0], ad[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (av[0] !== 1'b0 || ad[0] !== 32'd0 || ao[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%b d=%h o=%b exp 0/0/0",
               av[0], ad[0], ao[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 4);
    step(1, 0, 5);
    total++;
    if (av[0] !== 1'b0 || av[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_refill got v=%b exp 0", av[0]);
    end
    step(0, 0, 0);
  endtask

  task automatic test_stream();
    step(1, 0, 2);
    step(1, 0, 3);
    total++;
    if (av[0] !== 1'b0) begin
      bad++;
      $display("FAIL stream_early got v=%b exp 0", av[0]);
    end
    step(1, 0, 4);
    total++;
    if (av[0] !== 1'b1 || ad[0] !== 32'd10 || ao[0] !== 1'b0) begin
      bad++;
      $display("FAIL stream_first got v=%b d=%0d o=%b exp 1/10/0",
               av[0], ad[0], ao[0]);
    end
    step(1, 0, 5);
    total++;
    if (av[0] !== 1'b1 || ad[0] !== 32'd17) begin
      bad++;
      $display("FAIL stream_b2b got v=%b d=%0d exp 1/17",
               av[0], ad[0]);
    end
    step(0, 0, 0);
    total++;
    if (av[0] !== 1'b0 || ad[0] !== 32'd17 || ao[0] !== 1'b0) begin
      bad++;
      $display("FAIL stream_hold got v=%b d=%0d o=%b exp 0/17/0",
               av[0], ad[0], ao[0]);
    end
  endtask

  task automatic test_gap();
    logic seen;
    seen = 1'b0;
    step(1, 0, 7); seen |= av[0];
    step(1, 0, 8); seen |= av[0];
    step(0, 0, 0); seen |= av[0];
    step(1, 0, 1); seen |= av[0];
    step(1, 0, 1); seen |= av[0];
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL gap_novalid got seen=%b exp 0", seen);
    end
    step(1, 0, 2);
    total++;
    if (av[0] !== 1'b1 || ad[0] !== 32'd3) begin
      bad++;
      $display("FAIL gap_restart got v=%b d=%0d exp 1/3",
               av[0], ad[0]);
    end
    step(0, 0, 0);
  endtask

  task automatic test_ovf();
    step(1, 0, 32'h1_0000);
    step(1, 0, 32'h1_0000);
    step(1, 0, 32'd1);
    total++;
    if (av[0] !== 1'b1 || ad[0] !== 32'd1 || ao[0] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_wrap got v=%b d=%h o=%b exp 1/1/1",
               av[0], ad[0], ao[0]);
    end
    total++;
    if (av[1] !== 1'b1 || ad[1] !== 32'hFFFF_FFFF ||
        ao[1] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sat got v=%b d=%h o=%b exp 1/ffffffff/1",
               av[1], ad[1], ao[1]);
    end
    step(0, 0, 0);
    total++;
    if (ao[0] !== 1'b0 || ao[1] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pulse got o0=%b o1=%b exp 0/0",
               ao[0], ao[1]);
    end
  endtask

  task automatic test_clr();
    step(1, 0, 1);
    step(1, 0, 2);
    step(1, 1, 3);
    total++;
    if (av[0] !== 1'b0 || ad[0] !== 32'd0 || ao[0] !== 1'b0) begin
      bad++;
      $display("FAIL clr_flush got v=%b d=%h o=%b exp 0/0/0",
               av[0], ad[0], ao[0]);
    end
    step(1, 0, 1);
    step(1, 0, 2);
    total++;
    if (av[0] !== 1'b0) begin
      bad++;
      $display("FAIL clr_refill got v=%b exp 0", av[0]);
    end
    step(1, 0, 3);
    total++;
    if (av[0] !== 1'b1 || ad[0] !== 32'd5) begin
      bad++;
      $display("FAIL clr_after got v=%b d=%0d exp 1/5",
               av[0], ad[0]);
    end
    step(0, 0, 0);
  endtask

  task automatic test_narrow();
    step(1, 0, 255);
    step(1, 0, 255);
    step(1, 0, 255);
    total++;
    if (av[2] !== 1'b1 || ad[2] !== 32'd65280 ||
        ao[2] !== 1'b0) begin
      bad++;
      $display("FAIL narrow got v=%b d=%0d o=%b exp 1/65280/0",
               av[2], ad[2], ao[2]);
    end
    step(0, 0, 0);
  endtask

  task automatic test_random();
    bit          v, c;
    logic [31:0] d;
    for (int n = 0; n < 600; n++) begin
      v = $urandom_range(0, 7) != 0;
      c = $urandom_range(0, 24) == 0;
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(0, 15);
        1:       d = $urandom;
        2:       d = 32'hFFFF_FF00 | $urandom_range(0, 255);
        default: d = 32'h1_0000 << $urandom_range(0, 15);
      endcase
      step(v, c, d);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (av[k] !== ev[k] || ao[k] !== eo[k] ||
            ad[k] !== ed[k]) begin
          bad++;
          $display("FAIL rand dut%0d n=%0d got v=%b d=%h o=%b exp v=%b d=%h o=%b",
                   k, n, av[k], ad[k], ao[k],
                   ev[k], ed[k], eo[k]);
        end
      end
    end
    step(0, 0, 0);
  endtask

  initial begin
    if0.validi = 0; if0.clr = 0; if0.data_in = '0;
    if1.validi = 0; if1.clr = 0; if1.data_in = '0;
    if2.validi = 0; if2.clr = 0; if2.data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_stream();
    test_gap();
    test_ovf();
    test_clr();
    test_narrow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac3_stream.md
# mac3_stream

Parametrised streaming multiply-add unit: over a sliding window of three consecutive valid input samples it computes `a*b+c`. Here `a` is the sample two valid cycles back, `b` is one back, and `c` is the current sample. It generalises the fixed 32-bit `a*b+c` block with configurable widths, selectable wrap/saturate arithmetic, an overflow flag and a synchronous flush. It sits in the datapath exercise chain and is checked by a companion property module.

## Interface
Parameters:
- `DATA_W`, default 32: input sample width, unsigned.
- `ACC_W`, default 32: output width, `ACC_W` ≤ 2*DATA_W+1.
- `SATURATE`, default 0: overflow handling. 0 wraps (truncate to `ACC_W`); 1 clamps to 2^ACC_W−1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `validi`  in  1  `data_in` is a valid sample this cycle.
- `data_in`  in  `DATA_W`  input sample.
- `clr`  in  1  synchronous flush of window and outputs.
- `valido`  out  1  `data_out` holds a new result this cycle.
- `data_out`  out  `ACC_W`  result.
- `ovf`  out  1  result exceeded `ACC_W` range; qualified by `valido`.

## Operation
- Window registers `w1` (sample one back) and `w2` (sample two back) hold history.
- A fill state machine counts consecutive valid samples: EMPTY → ONE → TWO → FULL.
  - `validi`=1 advances the state one step; FULL stays FULL.
  - `validi`=0 in any state returns it to EMPTY. Window contents become don't-care, so a gap always restarts the fill.
- On `validi`=1: shift `w2`←`w1`, `w1`←`data_in`.
- A result is produced when `validi`=1 and the state is TWO or FULL. The current sample is the third or later consecutive valid sample.
  - Full-precision sum `s = w2*w1 + data_in`, width 2*DATA_W+1, unsigned.
  - `ovf` = 1 when `s` ≥ 2^ACC_W.
  - `data_out` = `s[ACC_W-1:0]` when SATURATE=0, or `ovf ? all-ones : s[ACC_W-1:0]` when SATURATE=1.
- `data_out` holds its last value while `valido`=0.
- `clr`=1 forces:
  - state to EMPTY;
  - `valido` to 0 and `ovf` to 0 next cycle;
  - `data_out` to 0 next cycle.
- `clr` and `validi` together: `clr` wins and the sample is discarded.
- Fewer than three consecutive valid samples never assert `valido`.

## Timing
- Reset (`rst_n`=0, asynchronous, at any time including mid-window):
  - state EMPTY;
  - `w1`, `w2` = 0;
  - `valido` = 0, `data_out` = 0, `ovf` = 0.
  - The first valid sample after release counts as sample 1.
- Latency: one cycle. The result for samples at cycles t−2, t−1, t appears with `valido`=1 at t+1, registered.
- Throughput: one result per cycle once FULL with `validi` held high.
- `valido` and `ovf` are single-cycle pulses per result. `ovf`=0 whenever `valido`=0.
- No backpressure. Results must be consumed in the cycle `valido` is high.

## Structure
- Package `mac3_pkg`:
  - `fill_e` enum (EMPTY, ONE, TWO, FULL);
  - function `mac3_sat(s, ACC_W, SATURATE)` returning the result and overflow.
- Sub-module `mac3_window` holds the fill state machine plus the `w1`/`w2` shift registers. It exports `win_full` (state is TWO/FULL and `validi`), `w1` and `w2`.
- Top `mac3_stream` holds the multiply-add, overflow/saturation logic and the output registers.

## Test plan
1. Reset mid-stream: drive 2, 3, then assert `rst_n`=0. Outputs are 0 immediately. After release, 4, 5 alone give no `valido`.
2. DATA_W=ACC_W=32, consecutive 2, 3, 4, 5: `valido` pulses the cycle after 4 with `data_out`=10, and the cycle after 5 with `data_out`=17.
3. Two-sample run 7, 8, gap, 1, 1: `valido` is never asserted. Then add 2: `data_out`=3.
4. Overflow with SATURATE=0 on 0x10000, 0x10000, 1: `data_out`=1, `ovf`=1. The same stimulus with SATURATE=1 gives `data_out`=0xFFFFFFFF, `ovf`=1.
5. `clr` asserted together with the third valid sample: no `valido`, `data_out`=0 next cycle. The next three samples 1, 2, 3 give `data_out`=5.
6. DATA_W=8, ACC_W=17, SATURATE=0, samples 255, 255, 255: `data_out`=65280, `ovf`=0.
